// File: rtl/lsu_ctrl_if.sv
// Handshake and SRAM-port bundle between EXU, lsu_ctrl, lsu_sram and WBU.
// The slave modport is the lsu_ctrl view; master is the surrounding environment.
interface lsu_ctrl_if #(
    parameter int unsigned CPU_WIDTH = 32
) ();
    localparam int unsigned MASK_W = CPU_WIDTH / 8;

    logic                 i_exu_valid;
    logic                 o_exu_ready;
    logic                 i_is_load;
    logic                 i_is_store;
    logic [2:0]           i_func3;
    logic [CPU_WIDTH-1:0] i_addr;
    logic [CPU_WIDTH-1:0] i_store_data;
    logic [4:0]           i_rd;

    logic                 o_mem_pre_valid;
    logic                 o_mem_ren;
    logic [CPU_WIDTH-1:0] o_mem_raddr;
    logic                 o_mem_wen;
    logic [CPU_WIDTH-1:0] o_mem_waddr;
    logic [MASK_W-1:0]    o_mem_wmask;
    logic [CPU_WIDTH-1:0] o_mem_wdata;
    logic [CPU_WIDTH-1:0] i_mem_rdata;
    logic                 i_mem_valid;

    logic                 o_wbu_valid;
    logic                 i_wbu_ready;
    logic [CPU_WIDTH-1:0] o_wbu_data;
    logic [4:0]           o_wbu_rd;
    logic                 o_err;

    modport slave (
        input  i_exu_valid, i_is_load, i_is_store, i_func3, i_addr, i_store_data, i_rd,
        input  i_mem_rdata, i_mem_valid, i_wbu_ready,
        output o_exu_ready, o_mem_pre_valid, o_mem_ren, o_mem_raddr, o_mem_wen,
        output o_mem_waddr, o_mem_wmask, o_mem_wdata, o_wbu_valid, o_wbu_data, o_wbu_rd, o_err
    );

    modport master (
        output i_exu_valid, i_is_load, i_is_store, i_func3, i_addr, i_store_data, i_rd,
        output i_mem_rdata, i_mem_valid, i_wbu_ready,
        input  o_exu_ready, o_mem_pre_valid, o_mem_ren, o_mem_raddr, o_mem_wen,
        input  o_mem_waddr, o_mem_wmask, o_mem_wdata, o_wbu_valid, o_wbu_data, o_wbu_rd, o_err
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store control stage in front of lsu_sram: one op in flight, word-aligned SRAM access,
// lane masking/replication for stores, load extraction/extension. Optional LSU_MISALIGN_CHK_EN.
module lsu_ctrl #(
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned CPU_WIDTH = 32
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    lsu_ctrl_if.slave      bus
);
    localparam int unsigned MASK_W = CPU_WIDTH / 8;
    localparam int unsigned CNT_W  = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    logic [1:0]           r_state, w_state_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [1:0]           r_off, w_off_nxt;
    logic [2:0]           r_func3, w_func3_nxt;
    logic [4:0]           r_rd, w_rd_nxt;
    logic                 r_is_load, w_is_load_nxt;

    logic                 r_exu_ready, w_exu_ready_nxt;
    logic                 r_mem_pre_valid, w_mem_pre_valid_nxt;
    logic                 r_mem_ren, w_mem_ren_nxt;
    logic [CPU_WIDTH-1:0] r_mem_raddr, w_mem_raddr_nxt;
    logic                 r_mem_wen, w_mem_wen_nxt;
    logic [CPU_WIDTH-1:0] r_mem_waddr, w_mem_waddr_nxt;
    logic [MASK_W-1:0]    r_mem_wmask, w_mem_wmask_nxt;
    logic [CPU_WIDTH-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic                 r_wbu_valid, w_wbu_valid_nxt;
    logic [CPU_WIDTH-1:0] r_wbu_data, w_wbu_data_nxt;
    logic [4:0]           r_wbu_rd, w_wbu_rd_nxt;
    logic                 r_err, w_err_nxt;

    logic [CPU_WIDTH-1:0] w_addr_aligned;
    logic [MASK_W-1:0]    w_st_mask;
    logic [CPU_WIDTH-1:0] w_st_data;
    logic [CPU_WIDTH-1:0] w_ld_sh;
    logic [CPU_WIDTH-1:0] w_ld_data;
    logic                 w_misalign;
    logic                 w_is_mem;

    assign w_addr_aligned = {bus.i_addr[CPU_WIDTH-1:2], 2'b00};
    assign w_is_mem       = bus.i_is_load | bus.i_is_store;
    assign w_cnt_inc      = r_cnt + CNT_W'(1);

`ifdef LSU_MISALIGN_CHK_EN
    assign w_misalign = (((bus.i_func3 == F_H) || (bus.i_func3 == F_HU)) && bus.i_addr[0])
                      || ((bus.i_func3 == F_W) && (bus.i_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // Store byte lanes and lane-replicated data, taken straight from the EXU inputs at accept.
    always_comb begin
        w_st_mask = '1;
        w_st_data = bus.i_store_data;
        case (bus.i_func3)
            F_B: begin
                w_st_mask = MASK_W'(1) << bus.i_addr[1:0];
                w_st_data = {MASK_W{bus.i_store_data[7:0]}};
            end
            F_H: begin
                w_st_mask = MASK_W'(3) << bus.i_addr[1:0];
                w_st_data = {(MASK_W/2){bus.i_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Load extraction from the registered SRAM word using the latched byte offset.
    always_comb begin
        w_ld_sh   = bus.i_mem_rdata >> {r_off, 3'b000};
        w_ld_data = w_ld_sh;
        case (r_func3)
            F_B:  w_ld_data = {{(CPU_WIDTH-8){w_ld_sh[7]}}, w_ld_sh[7:0]};
            F_BU: w_ld_data = {{(CPU_WIDTH-8){1'b0}}, w_ld_sh[7:0]};
            F_H:  w_ld_data = {{(CPU_WIDTH-16){w_ld_sh[15]}}, w_ld_sh[15:0]};
            F_HU: w_ld_data = {{(CPU_WIDTH-16){1'b0}}, w_ld_sh[15:0]};
            default: ;
        endcase
    end

    // Next-state and next-output logic; outputs are registered one step ahead of their state.
    always_comb begin
        w_state_nxt         = r_state;
        w_cnt_nxt           = r_cnt;
        w_off_nxt           = r_off;
        w_func3_nxt         = r_func3;
        w_rd_nxt            = r_rd;
        w_is_load_nxt       = r_is_load;
        w_exu_ready_nxt     = 1'b0;
        w_mem_pre_valid_nxt = 1'b0;
        w_mem_ren_nxt       = 1'b0;
        w_mem_raddr_nxt     = '0;
        w_mem_wen_nxt       = 1'b0;
        w_mem_waddr_nxt     = '0;
        w_mem_wmask_nxt     = '0;
        w_mem_wdata_nxt     = '0;
        w_wbu_valid_nxt     = 1'b0;
        w_wbu_data_nxt      = r_wbu_data;
        w_wbu_rd_nxt        = r_wbu_rd;
        w_err_nxt           = r_err;

        case (r_state)
            IDLE: begin
                if (bus.i_exu_valid) begin
                    if (w_is_mem && w_misalign) begin
                        w_state_nxt     = RESP;
                        w_wbu_valid_nxt = 1'b1;
                        w_wbu_data_nxt  = '0;
                        w_wbu_rd_nxt    = bus.i_is_store ? 5'd0 : bus.i_rd;
                        w_err_nxt       = 1'b1;
                    end else if (w_is_mem) begin
                        w_state_nxt         = REQ;
                        w_off_nxt           = bus.i_addr[1:0];
                        w_func3_nxt         = bus.i_func3;
                        w_rd_nxt            = bus.i_rd;
                        w_is_load_nxt       = bus.i_is_load;
                        w_mem_pre_valid_nxt = 1'b1;
                        if (bus.i_is_load) begin
                            w_mem_ren_nxt   = 1'b1;
                            w_mem_raddr_nxt = w_addr_aligned;
                        end else begin
                            w_mem_wen_nxt   = 1'b1;
                            w_mem_waddr_nxt = w_addr_aligned;
                            w_mem_wmask_nxt = w_st_mask;
                            w_mem_wdata_nxt = w_st_data;
                        end
                    end else begin
                        w_state_nxt     = RESP;
                        w_wbu_valid_nxt = 1'b1;
                        w_wbu_data_nxt  = bus.i_addr;
                        w_wbu_rd_nxt    = bus.i_rd;
                        w_err_nxt       = 1'b0;
                    end
                end else begin
                    w_exu_ready_nxt = 1'b1;
                end
            end
            REQ: begin
                w_state_nxt = WAIT;
                w_cnt_nxt   = '0;
            end
            WAIT: begin
                if (bus.i_mem_valid) begin
                    w_state_nxt     = RESP;
                    w_wbu_valid_nxt = 1'b1;
                    w_wbu_data_nxt  = r_is_load ? w_ld_data : '0;
                    w_wbu_rd_nxt    = r_is_load ? r_rd : 5'd0;
                    w_err_nxt       = 1'b0;
                end else if (w_cnt_inc == CNT_LAST) begin
                    w_state_nxt     = RESP;
                    w_wbu_valid_nxt = 1'b1;
                    w_wbu_data_nxt  = '0;
                    w_wbu_rd_nxt    = r_is_load ? r_rd : 5'd0;
                    w_err_nxt       = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            RESP: begin
                if (bus.i_wbu_ready) begin
                    w_state_nxt     = IDLE;
                    w_exu_ready_nxt = 1'b1;
                end else begin
                    w_wbu_valid_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt     = IDLE;
                w_exu_ready_nxt = 1'b1;
            end
        endcase
    end

    // State, operation context and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= IDLE;
            r_cnt           <= '0;
            r_off           <= '0;
            r_func3         <= '0;
            r_rd            <= '0;
            r_is_load       <= 1'b0;
            r_exu_ready     <= 1'b1;
            r_mem_pre_valid <= 1'b0;
            r_mem_ren       <= 1'b0;
            r_mem_raddr     <= '0;
            r_mem_wen       <= 1'b0;
            r_mem_waddr     <= '0;
            r_mem_wmask     <= '0;
            r_mem_wdata     <= '0;
            r_wbu_valid     <= 1'b0;
            r_wbu_data      <= '0;
            r_wbu_rd        <= '0;
            r_err           <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_cnt           <= w_cnt_nxt;
            r_off           <= w_off_nxt;
            r_func3         <= w_func3_nxt;
            r_rd            <= w_rd_nxt;
            r_is_load       <= w_is_load_nxt;
            r_exu_ready     <= w_exu_ready_nxt;
            r_mem_pre_valid <= w_mem_pre_valid_nxt;
            r_mem_ren       <= w_mem_ren_nxt;
            r_mem_raddr     <= w_mem_raddr_nxt;
            r_mem_wen       <= w_mem_wen_nxt;
            r_mem_waddr     <= w_mem_waddr_nxt;
            r_mem_wmask     <= w_mem_wmask_nxt;
            r_mem_wdata     <= w_mem_wdata_nxt;
            r_wbu_valid     <= w_wbu_valid_nxt;
            r_wbu_data      <= w_wbu_data_nxt;
            r_wbu_rd        <= w_wbu_rd_nxt;
            r_err           <= w_err_nxt;
        end
    end

    assign bus.o_exu_ready     = r_exu_ready;
    assign bus.o_mem_pre_valid = r_mem_pre_valid;
    assign bus.o_mem_ren       = r_mem_ren;
    assign bus.o_mem_raddr     = r_mem_raddr;
    assign bus.o_mem_wen       = r_mem_wen;
    assign bus.o_mem_waddr     = r_mem_waddr;
    assign bus.o_mem_wmask     = r_mem_wmask;
    assign bus.o_mem_wdata     = r_mem_wdata;
    assign bus.o_wbu_valid     = r_wbu_valid;
    assign bus.o_wbu_data      = r_wbu_data;
    assign bus.o_wbu_rd        = r_wbu_rd;
    assign bus.o_err           = r_err;
endmodule
